fadd_pipe: RTL and testbench
============================

FADD_PIPE -- requirements
Module: fadd_pipe

Interface
REQ-001 FTZ, 0, when 1 denormal inputs are treated as signed zero and denormal results are flushed to signed zero.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in1/in2 hold a valid operand pair this cycle.
REQ-005 in1  input  32  IEEE-754 single operand A; this is the FMul product stream.
REQ-006 in2  input  32  IEEE-754 single operand B (addend).
REQ-007 out_valid  output  1  out holds the sum of the pair accepted 3 cycles earlier.
REQ-008 out  output  32  IEEE-754 single sum in1+in2.

Function
REQ-009 The block shall accept one operand pair per cycle, with no backpressure and no stall.
REQ-010 Latency shall be exactly 3 cycles: a pair sampled at edge N shall appear with out_valid=1 after edge N+3.
REQ-011 Stage 1 shall unpack both operands, classify them (zero/denormal/normal/inf/NaN), swap so the larger magnitude is first, and align the smaller mantissa by the exponent difference, keeping guard, round and sticky bits; any shift of 26 or more shall collapse the smaller mantissa into sticky.
REQ-012 Stage 2 shall add or subtract the 27-bit aligned mantissas, selected by the XOR of the signs.
REQ-013 Stage 3 shall normalize using a leading-zero count (left shift limited so the exponent does not drop below 1), round to nearest with ties to even, and pack the result.
REQ-014 A carry-out after rounding shall increment the exponent.
REQ-015 An exponent of 255 or more after rounding shall produce a signed infinity.
REQ-016 With FTZ=0, denormal inputs shall use hidden bit 0 and exponent 1, and results below the smallest normal shall be emitted as denormals (gradual underflow).
REQ-017 Any NaN input, or inf + (-inf), shall produce 0x7FC00000.
REQ-018 inf + finite shall produce that infinity; inf + inf of the same sign shall produce that infinity.
REQ-019 An exact zero sum of operands with opposite signs shall produce +0; (-0)+(-0) shall produce -0.
REQ-020 A valid bit shall travel with each stage; when out_valid=0, out shall hold its last value.
REQ-021 Back-to-back pairs of mixed classes shall not interfere; each stage's state shall belong to its own pair only.

Reset
REQ-022 rst_n low shall immediately clear all stage valid bits, out_valid=0 and out=32'h00000000.
REQ-023 Pairs in flight when rst_n asserts shall be discarded and shall never appear at the output.
REQ-024 The first pair sampled on the first rising edge with rst_n high shall emerge 3 cycles later.

Structure
REQ-025 A shared package fp_pkg shall hold EXP_BIAS=127, EXP_MAX=255, MANT_W=23, QNAN=32'h7FC00000, POS_INF=32'h7F800000, and the operand-class enumeration; fmul and fadd_pipe shall both use it.
REQ-026 The leading-zero counter shall be a sub-module fp_lzc (27-bit input, 5-bit count, combinational), instantiated in stage 3.
REQ-027 Data registers shall need no reset; only valid bits and out shall be reset.

Verification
REQ-028 Pair 0x40000000 + 0x3FE3D70A (2.0+1.78) -> out=0x4071EB85 with out_valid exactly 3 cycles later.
REQ-029 Rounding: 0x3F800000+0x33800000 -> 0x3F800000 (tie to even); 0x3F800000+0x33C00000 -> 0x3F800001.
REQ-030 Specials: 0x3F800000+0xBF800000 -> 0x00000000; 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000; 0x7F800000+0xFF800000 -> 0x7FC00000.
REQ-031 Denormals: 0x00700000+0x00700000 -> 0x00E00000 (FTZ=0) and 0x00000000 (FTZ=1); 0x00400000+0x00400000 -> 0x00800000 (FTZ=0).
REQ-032 Streaming: six distinct pairs on consecutive cycles -> six correct results on consecutive cycles, in order.
REQ-033 Mid-flight reset: drive 2 valid pairs, pull rst_n low for 1 cycle -> out_valid=0 and out=0 immediately; no stale results appear after release.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, operand classes and classifier
//
// Purpose : common definitions for the floating-point datapath blocks (fmul, fadd_pipe).
// Contents: EXP_BIAS, EXP_MAX, MANT_W, QNAN, POS_INF, fp_class_t, fp_classify().

package fp_pkg;

   localparam int unsigned EXP_BIAS = 127;
   localparam int unsigned EXP_MAX  = 255;
   localparam int unsigned MANT_W   = 23;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_DENORM,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_t;

   function automatic fp_class_t fp_classify(input logic [31:0] x);
      fp_class_t c;
      if (x[30:23] == 8'd0)
         c = (x[22:0] == 23'd0) ? FP_ZERO : FP_DENORM;
      else if (x[30:23] == 8'hFF)
         c = (x[22:0] == 23'd0) ? FP_INF : FP_NAN;
      else
         c = FP_NORMAL;
      return c;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter for the 27-bit adder mantissa
//
// Purpose: number of zeros above the most significant set bit; 27 when the input is zero.
// Ports  : din [26:0] mantissa in, cnt [4:0] leading-zero count out.

module fp_lzc (
   input  logic [26:0] din,
   output logic [4:0]  cnt
);

   // Scanning upward lets the highest set bit make the final assignment.
   always_comb begin
      cnt = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (din[i])
            cnt = 5'(26 - i);
      end
   end

endmodule

// File: rtl/fadd_pipe.sv
// rtl/fadd_pipe.sv - three-cycle pipelined IEEE-754 single-precision adder
//
// Purpose : out = in1 + in2, round to nearest even, one pair per cycle, no stall.
//           FTZ=1 treats denormal inputs as signed zero and flushes denormal results.
// Ports   : clk, rst_n (async active-low), in_valid, in1[31:0], in2[31:0],
//           out_valid, out[31:0] (sum of the pair sampled three edges earlier).

module fadd_pipe
   import fp_pkg::*;
#(
   parameter bit FTZ = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic        out_valid,
   output logic [31:0] out
);

   // ---------------- stage 1: unpack, classify, swap, align ----------------
   fp_class_t   ca, cb;
   logic        a_zero, b_zero, a_ge_b;
   logic [7:0]  ea, eb, e_big, e_small, d;
   logic [23:0] sig_a, sig_b, sig_big, sig_small;
   logic [53:0] sh;
   logic [26:0] aligned;
   logic        any_nan, inf_clash, special1;
   logic [31:0] sval1;

   assign ca     = fp_classify(in1);
   assign cb     = fp_classify(in2);
   assign a_zero = (ca == FP_ZERO) || (FTZ && ca == FP_DENORM);
   assign b_zero = (cb == FP_ZERO) || (FTZ && cb == FP_DENORM);
   // Denormals (and zeros) behave as exponent 1 with hidden bit 0.
   assign ea     = (in1[30:23] == 8'd0) ? 8'd1 : in1[30:23];
   assign eb     = (in2[30:23] == 8'd0) ? 8'd1 : in2[30:23];
   assign sig_a  = a_zero ? 24'd0 : {ca == FP_NORMAL, in1[MANT_W-1:0]};
   assign sig_b  = b_zero ? 24'd0 : {cb == FP_NORMAL, in2[MANT_W-1:0]};

   assign a_ge_b    = {ea, sig_a} >= {eb, sig_b};
   assign e_big     = a_ge_b ? ea : eb;
   assign e_small   = a_ge_b ? eb : ea;
   assign sig_big   = a_ge_b ? sig_a : sig_b;
   assign sig_small = a_ge_b ? sig_b : sig_a;
   assign d         = e_big - e_small;

   // Low 27 bits of the wide shift are everything pushed past the sticky position.
   assign sh      = {sig_small, 3'b000, 27'd0} >> d;
   assign aligned = (d >= 8'd26) ? {26'd0, |sig_small}
                                 : {sh[53:28], sh[27] | (|sh[26:0])};

   assign any_nan   = (ca == FP_NAN) || (cb == FP_NAN);
   assign inf_clash = (ca == FP_INF) && (cb == FP_INF) && (in1[31] != in2[31]);
   assign special1  = any_nan || (ca == FP_INF) || (cb == FP_INF);
   assign sval1     = (any_nan || inf_clash) ? QNAN : ((ca == FP_INF) ? in1 : in2);

   logic        v1, s1_sub, s1_sign, s1_special;
   logic [7:0]  s1_exp;
   logic [26:0] s1_mbig, s1_msmall;
   logic [31:0] s1_sval;

   // ---------------- stage 2: add / subtract magnitudes ----------------
   logic [27:0] sum2;
   logic        sign2;

   assign sum2  = s1_sub ? ({1'b0, s1_mbig} - {1'b0, s1_msmall})
                         : ({1'b0, s1_mbig} + {1'b0, s1_msmall});
   // Exact cancellation yields +0; like-signed zeros keep their sign.
   assign sign2 = (s1_sub && sum2 == 28'd0) ? 1'b0 : s1_sign;

   logic        v2, s2_sign, s2_special;
   logic [7:0]  s2_exp;
   logic [27:0] s2_sum;
   logic [31:0] s2_sval;

   // ---------------- stage 3: normalize ----------------
   logic [4:0]  lz;
   logic [7:0]  limit, nsh;
   logic [26:0] norm3;
   logic [8:0]  exp3;

   fp_lzc u_lzc (
      .din (s2_sum[26:0]),
      .cnt (lz)
   );

   // Left shift stops at exponent 1 so tiny results fall out as denormals.
   assign limit = s2_exp - 8'd1;
   assign nsh   = ({3'b000, lz} > limit) ? limit : {3'b000, lz};
   assign norm3 = s2_sum[27] ? {s2_sum[27:2], s2_sum[1] | s2_sum[0]}
                             : (s2_sum[26:0] << nsh);
   assign exp3  = s2_sum[27] ? ({1'b0, s2_exp} + 9'd1) : {1'b0, s2_exp - nsh};

   logic        v3, s3_sign, s3_zero, s3_special;
   logic [8:0]  s3_exp;
   logic [26:0] s3_norm;
   logic [31:0] s3_sval;

   // ---------------- round and pack ----------------
   logic              round_up;
   logic [24:0]       sig_r;
   logic [8:0]        exp_f;
   logic [MANT_W-1:0] mant_f;
   logic [31:0]       res;

   assign round_up = s3_norm[2] & (s3_norm[3] | s3_norm[1] | s3_norm[0]);
   assign sig_r    = {1'b0, s3_norm[26:3]} + {24'd0, round_up};

   always_comb begin
      exp_f  = 9'd0;
      mant_f = sig_r[MANT_W-1:0];
      if (sig_r[24]) begin
         exp_f  = s3_exp + 9'd1;
         mant_f = '0;
      end else if (sig_r[23]) begin
         exp_f  = s3_exp;
      end

      if (s3_special)
         res = s3_sval;
      else if (s3_zero)
         res = {s3_sign, 31'd0};
      else if (exp_f >= 9'(EXP_MAX))
         res = POS_INF | {s3_sign, 31'd0};
      else if (FTZ && exp_f == 9'd0)
         res = {s3_sign, 31'd0};
      else
         res = {s3_sign, exp_f[7:0], mant_f};
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      s1_sub     <= in1[31] ^ in2[31];
      s1_sign    <= a_ge_b ? in1[31] : in2[31];
      s1_exp     <= e_big;
      s1_mbig    <= {sig_big, 3'b000};
      s1_msmall  <= aligned;
      s1_special <= special1;
      s1_sval    <= sval1;

      s2_sum     <= sum2;
      s2_sign    <= sign2;
      s2_exp     <= s1_exp;
      s2_special <= s1_special;
      s2_sval    <= s1_sval;

      s3_norm    <= norm3;
      s3_exp     <= exp3;
      s3_sign    <= s2_sign;
      s3_zero    <= (s2_sum == 28'd0);
      s3_special <= s2_special;
      s3_sval    <= s2_sval;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         out       <= 32'h00000000;
      end else begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         if (v3)
            out <= res;
      end
   end

endmodule

// File: tb/tb_fadd_pipe.sv
// tb/tb_fadd_pipe.sv - directed self-checking bench for fadd_pipe (FTZ=0 and FTZ=1 instances)

module tb_fadd_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in1 = 32'd0;
   logic [31:0] in2 = 32'd0;
   logic        out_valid, out_valid_z;
   logic [31:0] out, out_z;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fadd_pipe #(.FTZ(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
      .out_valid(out_valid), .out(out)
   );

   fadd_pipe #(.FTZ(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in1(in1), .in2(in2),
      .out_valid(out_valid_z), .out(out_z)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One isolated pair: out_valid must still be low after edge N+2 and high after N+3.
   task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [31:0] exp_z);
      @(negedge clk);
      in1 = a; in2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check(tag, out, exp);
      check({tag, "_ftz"}, out_z, exp_z);
   endtask

   logic [31:0] sa [6];
   logic [31:0] sb [6];
   logic [31:0] se [6];
   logic [31:0] sz [6];

   initial begin
      #1;
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out", out, 32'h00000000);
      @(negedge clk);
      rst_n = 1'b1;

      single("add_2_178",   32'h40000000, 32'h3FE3D70A, 32'h4071EB85, 32'h4071EB85);
      single("tie_even",    32'h3F800000, 32'h33800000, 32'h3F800000, 32'h3F800000);
      single("round_up",    32'h3F800000, 32'h33C00000, 32'h3F800001, 32'h3F800001);
      single("cancel",      32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000);
      single("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000);
      single("inf_clash",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000);
      single("denorm_sum",  32'h00700000, 32'h00700000, 32'h00E00000, 32'h00000000);
      single("denorm_norm", 32'h00400000, 32'h00400000, 32'h00800000, 32'h00000000);
      single("neg_zeros",   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
      single("inf_fin",     32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h7F800000);
      single("ninf_ninf",   32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000);
      single("nan_in",      32'h3F800000, 32'h7F800001, 32'h7FC00000, 32'h7FC00000);
      single("sub_simple",  32'h3FC00000, 32'hBE800000, 32'h3FA00000, 32'h3FA00000);
      single("near_cancel", 32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 32'h33800000);
      single("to_denorm",   32'h00800000, 32'h80000001, 32'h007FFFFF, 32'h00800000);

      // Six mixed-class pairs on consecutive cycles.
      sa[0] = 32'h40000000; sb[0] = 32'h3FE3D70A; se[0] = 32'h4071EB85; sz[0] = 32'h4071EB85;
      sa[1] = 32'h7F800001; sb[1] = 32'h3F800000; se[1] = 32'h7FC00000; sz[1] = 32'h7FC00000;
      sa[2] = 32'h3F800000; sb[2] = 32'hBF800000; se[2] = 32'h00000000; sz[2] = 32'h00000000;
      sa[3] = 32'h3F800000; sb[3] = 32'h33C00000; se[3] = 32'h3F800001; sz[3] = 32'h3F800001;
      sa[4] = 32'h7F7FFFFF; sb[4] = 32'h7F7FFFFF; se[4] = 32'h7F800000; sz[4] = 32'h7F800000;
      sa[5] = 32'h00700000; sb[5] = 32'h00700000; se[5] = 32'h00E00000; sz[5] = 32'h00000000;
      for (int t = 0; t < 11; t++) begin
         @(negedge clk);
         if (t >= 4 && t < 10) begin
            check($sformatf("stream%0d_valid", t - 4), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d", t - 4), out, se[t - 4]);
            check($sformatf("stream%0d_ftz", t - 4), out_z, sz[t - 4]);
         end
         if (t == 10)
            check("stream_end_valid", {31'd0, out_valid}, 32'd0);
         if (t < 6) begin
            in1 = sa[t]; in2 = sb[t]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end

      // Mid-flight reset: two pairs enter, then reset wipes them.
      @(negedge clk);
      in1 = 32'h40000000; in2 = 32'h3FE3D70A; in_valid = 1'b1;
      @(negedge clk);
      in1 = 32'h3F800000; in2 = 32'h3F800000;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out", out, 32'h00000000);
      check("midrst_valid_ftz", {31'd0, out_valid_z}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("no_stale%0d", k), {31'd0, out_valid}, 32'd0);
      end
      check("no_stale_out", out, 32'h00000000);

      single("after_reset", 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
